ham_encoder_tx: RTL and testbench

//  Upstream stage of the Hamming(7,4) link: accepts 4-bit data nibbles on a valid/ready

---
 rtl/ham_encoder_tx.sv | 197 +++++++++++++++++++
 tb/tb_ham_encoder_tx.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/ham_encoder_tx.sv
// ---------------------------------------------------------------------------
// ham_encoder_tx
//
// Transmit side of the Hamming(7,4) link. Data nibbles arrive on a
// valid/ready interface. Each one is encoded into a 7-bit codeword, written
// into a small show-ahead FIFO, and presented to the decoder side on a second
// valid/ready interface.
//
// Optional single-bit error injection is built only when the macro
// HAM_ERR_INJ_EN is defined. In the default build, err_pos and err_arm are
// ignored and inj_count is tied to zero.
//
// Parameters
//   FIFO_DEPTH  codeword buffer entries (power of two, >= 2)
//   CNT_W       width of tx_count and inj_count
//
// Ports
//   clk        single clock; all state changes on the rising edge
//   rst        synchronous active-high reset
//   in_data    data nibble {d4,d3,d2,d1}
//   in_valid   in_data is valid
//   in_ready   a nibble can be accepted this cycle
//   out_cw     codeword; bit i-1 holds Hamming position i
//   out_valid  out_cw is valid
//   out_ready  the consumer takes out_cw this cycle
//   err_pos    injection position: 0 = none, 1..7 = flip that position
//   err_arm    one-cycle pulse that latches err_pos and arms one injection
//   tx_count   number of codewords delivered (output handshakes)
//   inj_count  number of codewords written with an injected error
// ---------------------------------------------------------------------------
module ham_encoder_tx #(
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [6:0]       out_cw,
    output logic             out_valid,
    input  logic             out_ready,
    input  logic [2:0]       err_pos,
    input  logic             err_arm,
    output logic [CNT_W-1:0] tx_count,
    output logic [CNT_W-1:0] inj_count
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int OCC_W = PTR_W + 1;

    // Hamming(7,4) encoder. Result layout is {p1,p2,d1,p3,d2,d3,d4} for
    // positions 1..7, stored LSB first.
    function automatic logic [6:0] ham_encode(input logic [3:0] d);
        logic p1, p2, p3;
        p1 = d[0] ^ d[1] ^ d[3];
        p2 = d[0] ^ d[2] ^ d[3];
        p3 = d[1] ^ d[2] ^ d[3];
        return {d[3], d[2], d[1], p3, d[0], p2, p1};
    endfunction

    logic [6:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [OCC_W-1:0] occ;
    logic [6:0]       last_cw;
    logic             full;
    logic             empty;
    logic             do_push;
    logic             do_pop;
    logic [6:0]       inj_mask;
    logic [6:0]       wr_cw;

    assign full      = (occ == OCC_W'(FIFO_DEPTH));
    assign empty     = (occ == '0);
    assign in_ready  = !full && !rst;
    assign out_valid = !empty;
    assign do_push   = in_valid && in_ready;
    assign do_pop    = out_valid && out_ready;

    // When the FIFO is empty, last_cw keeps the most recently delivered
    // codeword on the output. After reset it holds zero, so entries left in
    // the memory array can never reach out_cw.
    assign out_cw = empty ? last_cw : mem[rd_ptr];

    // The encoding and any injected flip are applied here, so the FIFO
    // stores final codewords.
    assign wr_cw = ham_encode(in_data) ^ inj_mask;

    // Storage: write stage
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_cw;
        end
    end

    // Pointer and occupancy control: a simultaneous push and pop leave the
    // occupancy unchanged.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   occ <= occ + OCC_W'(1);
                2'b01:   occ <= occ - OCC_W'(1);
                default: occ <= occ;
            endcase
        end
    end

    // Delivered-codeword holding register and delivery counter
    always_ff @(posedge clk) begin
        if (rst) begin
            last_cw  <= '0;
            tx_count <= '0;
        end else if (do_pop) begin
            last_cw  <= mem[rd_ptr];
            tx_count <= tx_count + CNT_W'(1);
        end
    end

`ifdef HAM_ERR_INJ_EN

    typedef enum logic {
        IDLE  = 1'b0,
        ARMED = 1'b1
    } inj_state_t;

    inj_state_t state;
    inj_state_t state_nxt;
    logic [2:0] err_pos_q;
    logic       inj_fire;

    // Injection FSM: state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            err_pos_q <= '0;
            inj_count <= '0;
        end else begin
            state <= state_nxt;
            if (err_arm && (err_pos != 3'd0)) begin
                err_pos_q <= err_pos;
            end
            if (inj_fire) begin
                inj_count <= inj_count + CNT_W'(1);
            end
        end
    end

    // Injection FSM: next state and mask. A write in ARMED uses the
    // err_pos_q value from before this edge. An err_arm pulse in the same
    // cycle then decides the next state, so it can re-arm immediately.
    always_comb begin
        state_nxt = state;
        inj_fire  = 1'b0;
        inj_mask  = 7'd0;
        case (state)
            IDLE: begin
                state_nxt = IDLE;
            end
            ARMED: begin
                if (do_push) begin
                    inj_fire  = 1'b1;
                    inj_mask  = 7'd1 << (err_pos_q - 3'd1);
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
        if (err_arm) begin
            state_nxt = (err_pos != 3'd0) ? ARMED : IDLE;
        end
    end

`else

    // Injection is not built: every codeword is written clean.
    logic unused_inj;

    assign unused_inj = ^{err_pos, err_arm};
    assign inj_mask   = 7'd0;
    assign inj_count  = '0;

`endif

endmodule

// File: tb/tb_ham_encoder_tx.sv
module tb_ham_encoder_tx;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic [6:0]  out_cw;
    logic        out_valid;
    logic        out_ready;
    logic [2:0]  err_pos;
    logic        err_arm;
    logic [15:0] tx_count;
    logic [15:0] inj_count;

    int n_chk  = 0;
    int n_fail = 0;
    int n_pop  = 0;
    bit syn_en = 1'b0;
    logic [6:0] sb [$];

    ham_encoder_tx #(.FIFO_DEPTH(4), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .out_cw(out_cw), .out_valid(out_valid),
        .out_ready(out_ready), .err_pos(err_pos), .err_arm(err_arm),
        .tx_count(tx_count), .inj_count(inj_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference encoder: place the data bits, then choose parity bits so
    // that the XOR of the set positions is zero.
    function automatic logic [6:0] ref_enc(input logic [3:0] d);
        logic [6:0] cw;
        logic [2:0] s;
        cw = '0;
        s = '0;
        cw[2] = d[0]; cw[4] = d[1]; cw[5] = d[2]; cw[6] = d[3];
        for (int i = 1; i <= 7; i++) if (cw[i-1]) s ^= i[2:0];
        cw[0] = s[0]; cw[1] = s[1]; cw[3] = s[2];
        return cw;
    endfunction

    function automatic logic [2:0] syndrome(input logic [6:0] cw);
        logic [2:0] s;
        s = '0;
        for (int i = 1; i <= 7; i++) if (cw[i-1]) s ^= i[2:0];
        return s;
    endfunction

    // Output monitor
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            n_pop++;
            if (sb.size() == 0) begin
                chk("unexpected_out", 32'(out_cw), 32'h80);
            end else begin
                chk("out_cw", 32'(out_cw), 32'(sb.pop_front()));
                if (syn_en) chk("syndrome", 32'(syndrome(out_cw)), 0);
            end
        end
    end

    task automatic send(input logic [3:0] nib, input logic [6:0] flip);
        int waitc;
        waitc = 0;
        in_data = nib;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && waitc < 50) begin
            @(negedge clk);
            waitc++;
        end
        if (!in_ready) chk("send_timeout", 0, 1);
        else sb.push_back(ref_enc(nib) ^ flip);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int waitc;
        waitc = 0;
        out_ready = 1'b1;
        while (sb.size() != 0 && waitc < 100) begin
            @(posedge clk); #1;
            waitc++;
        end
        chk("drain_left", sb.size(), 0);
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic pop1();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1; in_data = '0; in_valid = 1'b0; out_ready = 1'b0;
        err_pos = '0; err_arm = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", 32'(in_ready), 1);
        chk("post_rst_out_valid", 32'(out_valid), 0);
        chk("post_rst_out_cw", 32'(out_cw), 0);
        chk("post_rst_tx_count", 32'(tx_count), 0);
        chk("post_rst_inj_count", 32'(inj_count), 0);
        @(posedge clk); #1;

        // Test 1: a single codeword, its latency and hold after the pop
        send(4'b1101, 7'd0);
        @(negedge clk);
        chk("t1_out_valid", 32'(out_valid), 1);
        chk("t1_out_cw", 32'(out_cw), 32'h66);
        @(posedge clk); #1;
        pop1();
        @(negedge clk);
        chk("t1_tx_count", 32'(tx_count), 1);
        chk("t1_empty", 32'(out_valid), 0);
        chk("t1_hold_cw", 32'(out_cw), 32'h66);
        @(posedge clk); #1;

        // Test 2: exhaustive encode with the consumer always ready
        syn_en = 1'b1;
        out_ready = 1'b1;
        for (int n = 0; n < 16; n++) send(4'(n), 7'd0);
        drain();
        syn_en = 1'b0;

        // Test 3: fill under backpressure; the 5th nibble waits for a pop
        for (int n = 0; n < 4; n++) send(4'(n + 9), 7'd0);
        in_data = 4'hE;
        in_valid = 1'b1;
        @(negedge clk);
        chk("t3_full_ready", 32'(in_ready), 0);
        chk("t3_head", 32'(out_cw), 32'(ref_enc(4'h9)));
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(negedge clk);
        chk("t3_ready_in_pop", 32'(in_ready), 0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("t3_ready_after_pop", 32'(in_ready), 1);
        if (in_ready) sb.push_back(ref_enc(4'hE));
        @(posedge clk); #1;
        in_valid = 1'b0;
        drain();

`ifdef HAM_ERR_INJ_EN
        // Test 4: a single injection at position 5, then a clean write
        err_pos = 3'd5; err_arm = 1'b1;
        @(posedge clk); #1;
        err_arm = 1'b0;
        send(4'b1101, 7'b0010000);
        @(negedge clk);
        chk("t4_inj_cw", 32'(out_cw), 32'h76);
        chk("t4_inj_count", 32'(inj_count), 1);
        @(posedge clk); #1;
        pop1();
        send(4'b1101, 7'd0);
        @(negedge clk);
        chk("t4_clean_cw", 32'(out_cw), 32'h66);
        chk("t4_inj_count2", 32'(inj_count), 1);
        @(posedge clk); #1;
        pop1();
`else
        // Test 6: injection is not built, so arming has no effect
        err_pos = 3'd3; err_arm = 1'b1;
        @(posedge clk); #1;
        err_arm = 1'b0;
        send(4'b0000, 7'd0);
        @(negedge clk);
        chk("t6_clean_cw", 32'(out_cw), 0);
        chk("t6_inj_count", 32'(inj_count), 0);
        @(posedge clk); #1;
        pop1();
`endif
        @(negedge clk);
        chk("tx_count_total", 32'(tx_count), 32'(n_pop));
        @(posedge clk); #1;

        // Test 5: reset with three entries queued
        for (int n = 0; n < 3; n++) send(4'(n + 3), 7'd0);
        rst = 1'b1;
        @(negedge clk);
        chk("t5_rst_in_ready", 32'(in_ready), 0);
        @(posedge clk); #1;
        sb.delete();
        n_pop = 0;
        @(negedge clk);
        chk("t5_out_valid", 32'(out_valid), 0);
        chk("t5_out_cw", 32'(out_cw), 0);
        chk("t5_tx_count", 32'(tx_count), 0);
        chk("t5_inj_count", 32'(inj_count), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("t5_in_ready", 32'(in_ready), 1);
        repeat (3) begin
            @(negedge clk);
            chk("t5_no_stale", 32'(out_valid), 0);
        end
        @(posedge clk); #1;
        send(4'hA, 7'd0);
        drain();
        @(negedge clk);
        chk("t5_tx_count_after", 32'(tx_count), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
